// File: rtl/decode_regfile_pkg.sv
// Shared processor package for the decode stage.
// Holds the default datapath/register-file sizes and the instruction field
// bit positions used to slice the fetched instruction word.
package decode_regfile_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;

    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RS1_MSB    = 19;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_MSB    = 24;
    localparam int unsigned RS2_LSB    = 20;

    localparam int unsigned OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;

endpackage : decode_regfile_pkg

// File: rtl/decode_regfile_regfile_array.sv
// Register array: NREG x XLEN, register 0 hard-wired to zero.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset (clears all)
//   we, waddr, wdata        - synchronous write port (writes to index 0 dropped)
//   raddr1/rdata1,
//   raddr2/rdata2           - two asynchronous read ports
import decode_regfile_pkg::*;

module regfile_array #(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule : regfile_array

// File: rtl/decode_regfile.sv
// Decode stage with integrated register file.
// Accepts an instruction from fetch, reads (with write-back bypass) its two
// source operands and presents them with rd/opcode to execute one cycle later
// over a valid/ready handshake.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   in_valid, in_ready, instr  - fetch-side handshake and instruction word
//   flush                      - drop the held or arriving instruction
//   wb_en, wb_addr, wb_data    - register write-back
//   out_valid, out_ready       - execute-side handshake
//   rs1_data, rs2_data         - source operands
//   rd_addr, opcode            - destination index and opcode
import decode_regfile_pkg::*;

module decode_regfile #(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic [AW-1:0]       rd_addr,
    output logic [OPCODE_W-1:0] opcode
);

    logic [AW-1:0]       rs1_idx;
    logic [AW-1:0]       rs2_idx;
    logic [AW-1:0]       rd_idx;
    logic [OPCODE_W-1:0] opc;
    logic [XLEN-1:0]     arr_rd1;
    logic [XLEN-1:0]     arr_rd2;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic                transfer;
    logic                hold;
    // Source indices of the held instruction, kept so write-backs that land
    // while execute stalls can refresh the held operands.
    logic [AW-1:0]       rs1_idx_q;
    logic [AW-1:0]       rs2_idx_q;
    logic                unused_instr_bits;

    assign rs1_idx = AW'(instr[RS1_MSB:RS1_LSB]);
    assign rs2_idx = AW'(instr[RS2_MSB:RS2_LSB]);
    assign rd_idx  = AW'(instr[RD_MSB:RD_LSB]);
    assign opc     = instr[OPCODE_MSB:OPCODE_LSB];
    assign unused_instr_bits = ^{instr[31:25], instr[14:12]};

    regfile_array #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1_idx),
        .rdata1 (arr_rd1),
        .raddr2 (rs2_idx),
        .rdata2 (arr_rd2)
    );

    assign in_ready = !out_valid || out_ready;
    assign transfer = in_valid && in_ready && !flush;
    assign hold     = out_valid && !out_ready;

    // Same-cycle write-back bypass for the arriving instruction.
    always_comb begin
        src1 = arr_rd1;
        src2 = arr_rd2;
        if (wb_en && (wb_addr == rs1_idx) && (rs1_idx != '0)) begin
            src1 = wb_data;
        end
        if (wb_en && (wb_addr == rs2_idx) && (rs2_idx != '0)) begin
            src2 = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            rd_addr   <= '0;
            opcode    <= '0;
            rs1_idx_q <= '0;
            rs2_idx_q <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            rs1_data  <= src1;
            rs2_data  <= src2;
            rd_addr   <= rd_idx;
            opcode    <= opc;
            rs1_idx_q <= rs1_idx;
            rs2_idx_q <= rs2_idx;
        end else if (hold) begin
            if (wb_en && (wb_addr == rs1_idx_q) && (rs1_idx_q != '0)) begin
                rs1_data <= wb_data;
            end
            if (wb_en && (wb_addr == rs2_idx_q) && (rs2_idx_q != '0)) begin
                rs2_data <= wb_data;
            end
        end else begin
            // Empty, or drained by execute with nothing new arriving; the
            // payload registers keep their last values.
            out_valid <= 1'b0;
        end
    end

endmodule : decode_regfile

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile (XLEN=64, NREG=16).
module tb_decode_regfile;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;

    typedef struct packed {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [3:0]  rd;
        logic [6:0]  opc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            flush;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [AW-1:0]   rd_addr;
    logic [6:0]      opcode;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [63:0] model [NREG];

    decode_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .flush     (flush),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_addr   (rd_addr),
        .opcode    (opcode)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk(input int rs1, input int rs2, input int rd, input int opc);
        logic [31:0] w;
        w        = '0;
        w[19:15] = 5'(rs1);
        w[24:20] = 5'(rs2);
        w[11:7]  = 5'(rd);
        w[6:0]   = 7'(opc);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an instruction and record its expected decode from the model,
    // including the bypass when a write-back to a source lands this cycle.
    task automatic send(input int rs1, input int rs2, input int rd, input int opc);
        exp_t e;
        in_valid = 1'b1;
        instr    = mk(rs1, rs2, rd, opc);
        e.rs1 = (rs1 == 0) ? 64'd0 : model[rs1];
        e.rs2 = (rs2 == 0) ? 64'd0 : model[rs2];
        if (wb_en && rs1 != 0 && int'(wb_addr) == rs1) e.rs1 = wb_data;
        if (wb_en && rs2 != 0 && int'(wb_addr) == rs2) e.rs2 = wb_data;
        e.rd  = 4'(rd);
        e.opc = 7'(opc);
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rs1"}, rs1_data, e.rs1);
            chk({tag, "_rs2"}, rs2_data, e.rs2);
            chk({tag, "_rd"},  64'(rd_addr), 64'(e.rd));
            chk({tag, "_opc"}, 64'(opcode),  64'(e.opc));
        end
    endtask

    task automatic wb(input int addr, input logic [63:0] data);
        wb_en   = 1'b1;
        wb_addr = 4'(addr);
        wb_data = data;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        for (int i = 0; i < int'(NREG); i++) model[i] = 64'd0;

        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_rs1",       rs1_data,       64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic read: x5 written, then rs1=5, rs2=0.
        wb(5, 64'hAA);
        tick();
        model[5] = 64'hAA;
        wb_en = 1'b0;
        send(5, 0, 1, 'h33);
        tick();
        in_valid = 1'b0;
        check_out("basic");
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Bypass: x3 written in the transfer cycle.
        wb(3, 64'h1234);
        send(3, 5, 2, 'h13);
        tick();
        model[3] = 64'h1234;
        wb_en = 1'b0; in_valid = 1'b0;
        check_out("bypass");
        tick();

        // Hold with write to held rs2 (x7); a new instr offered is refused.
        out_ready = 1'b0;
        send(1, 7, 4, 'h23);
        tick();
        chk("hold_valid",    64'(out_valid), 64'd1);
        chk("hold_in_ready", 64'(in_ready),  64'd0);
        in_valid = 1'b1;
        instr    = mk(2, 2, 9, 'h7F);
        wb(7, 64'hBEEF);
        tick();
        model[7] = 64'hBEEF;
        sb[0].rs2 = 64'hBEEF;
        wb_en = 1'b0; in_valid = 1'b0;
        chk("hold2_valid",    64'(out_valid), 64'd1);
        chk("hold2_in_ready", 64'(in_ready),  64'd0);
        out_ready = 1'b1;
        check_out("hold_upd");
        tick();

        // Write to x0 is dropped.
        wb(0, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        wb_en = 1'b0;
        send(0, 3, 5, 'h03);
        tick();
        in_valid = 1'b0;
        check_out("x0");
        tick();

        // Flush while holding with a new instruction arriving.
        out_ready = 1'b0;
        send(5, 3, 6, 'h67);
        tick();
        chk("pre_flush_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        instr = mk(7, 7, 8, 'h0F);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        void'(sb.pop_front());
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_rd_kept", 64'(rd_addr), 64'd6);
        chk("flush_rs1_kept", rs1_data, 64'hAA);
        out_ready = 1'b1;
        send(5, 3, 10, 'h13);
        tick();
        in_valid = 1'b0;
        check_out("post_flush");
        tick();

        // Reset asserted mid-hold, with a coincident write-back.
        out_ready = 1'b0;
        send(7, 5, 9, 'h33);
        tick();
        in_valid = 1'b0;
        check_out("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid",    64'(out_valid), 64'd0);
        chk("mid_rst_rs1",      rs1_data,       64'd0);
        chk("mid_rst_rs2",      rs2_data,       64'd0);
        chk("mid_rst_rd",       64'(rd_addr),   64'd0);
        chk("mid_rst_opc",      64'(opcode),    64'd0);
        chk("mid_rst_in_ready", 64'(in_ready),  64'd1);
        sb.delete();
        for (int i = 0; i < int'(NREG); i++) model[i] = 64'd0;
        wb(5, 64'h55);
        tick();
        wb_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < int'(NREG); i++) begin
            send(i, int'(NREG) - 1 - i, i, 'h33);
            tick();
            in_valid = 1'b0;
            check_out($sformatf("clr%0d", i));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_decode_regfile
